// File: rtl/swt16_pkg.sv
// -----------------------------------------------------------------------------
// swt16_pkg
// Shared definitions for the swt16 core: datapath width constants, the
// memory-access stage FSM state encoding and the default DMEM timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package swt16_pkg;

   localparam int DMEM_ADDR_WIDTH = 12;
   localparam int DMEM_WORD_WIDTH = 16;
   localparam int IALU_WORD_WIDTH = 16;
   localparam int PC_WIDTH        = 12;
   localparam int PMEM_WORD_WIDTH = 16;
   localparam int REG_IDX_WIDTH   = 4;

   // Cycles to wait for the data-memory ack before the access is aborted.
   localparam int DMEM_TIMEOUT    = 15;

   typedef enum logic {
      MA_IDLE = 1'b0,
      MA_WAIT = 1'b1
   } ma_state_e;

endpackage : swt16_pkg

// File: rtl/dmem_req_fsm.sv
// -----------------------------------------------------------------------------
// dmem_req_fsm
// Request sequencer of the memory-access stage: IDLE/WAIT FSM, timeout
// counter, and generation of req / stall / completion / abort / err.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_op_valid            a load or store is held in the stage register
//   in_op_illegal          load and store were both requested
//   in_ack                 memory completes the current access
//   out_req                request to the data memory
//   out_stall              upstream must hold its outputs
//   out_complete           the held operation finishes this cycle
//   out_abort              the held operation finishes by timeout
//   out_err                one-cycle pulse: timeout or illegal op
// -----------------------------------------------------------------------------
module dmem_req_fsm
   import swt16_pkg::*;
#(
   parameter int TIMEOUT = DMEM_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic in_op_valid,
   input  logic in_op_illegal,
   input  logic in_ack,
   output logic out_req,
   output logic out_stall,
   output logic out_complete,
   output logic out_abort,
   output logic out_err
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   ma_state_e        r_state;
   ma_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_req;
   logic             w_complete;
   logic             w_abort;
   logic             w_err;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= MA_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_req       = 1'b0;
      w_complete  = 1'b0;
      w_abort     = 1'b0;
      w_err       = 1'b0;
      unique case (r_state)
         MA_IDLE: begin
            if (in_op_valid) begin
               w_req = 1'b1;
               // The illegal-combination flag fires once, in the issue cycle.
               w_err = in_op_illegal;
               if (in_ack) begin
                  w_complete = 1'b1;
               end else begin
                  w_state_nxt = MA_WAIT;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         MA_WAIT: begin
            w_req = 1'b1;
            if (in_ack) begin
               // A late ack wins over a simultaneous timeout.
               w_complete  = 1'b1;
               w_state_nxt = MA_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LIMIT) begin
               w_complete  = 1'b1;
               w_abort     = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = MA_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = MA_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are forced low while reset is high, which also drops an
   // outstanding request immediately without an error pulse.
   assign out_req      = w_req      & ~reset;
   assign out_complete = w_complete & ~reset;
   assign out_abort    = w_abort    & ~reset;
   assign out_err      = w_err      & ~reset;
   assign out_stall    = in_op_valid & ~w_complete & ~reset;

endmodule : dmem_req_fsm

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory-access stage of the swt16 core (between EX and WB). Captures the EX
// outputs into a stage register, issues loads/stores on a req/ack data-memory
// port with variable latency, stalls upstream while an access is outstanding
// and returns either the load word or the IALU result to WB.
// Ports:
//   clock, reset                  rising-edge clock, sync active-high reset
//   in_act_*                      load / store / register-write actions
//   in_dmem_rd/wr_addr, wr_word   access addresses and store data
//   in_instr, in_pc               passed through to WB
//   in_res, in_res_reg_idx        EX result and destination register
//   in_dmem_ack, in_dmem_rdata    memory completion and load data
//   out_dmem_req/we/addr/wdata    data-memory request
//   out_stall                     upstream must hold
//   out_act_write_res_to_reg      WB write enable
//   out_res, out_res_reg_idx      result and destination register
//   out_res_valid                 out_res usable for forwarding
//   out_instr, out_pc             passed through
//   out_dmem_err                  pulse: timeout or illegal load+store
// -----------------------------------------------------------------------------
module mem_access
   import swt16_pkg::*;
#(
   parameter int P_DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int P_DMEM_WORD_WIDTH = DMEM_WORD_WIDTH,
   parameter int P_IALU_WORD_WIDTH = IALU_WORD_WIDTH,
   parameter int P_PC_WIDTH        = PC_WIDTH,
   parameter int P_PMEM_WORD_WIDTH = PMEM_WORD_WIDTH,
   parameter int P_REG_IDX_WIDTH   = REG_IDX_WIDTH,
   parameter int P_DMEM_TIMEOUT    = DMEM_TIMEOUT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_act_load_dmem,
   input  logic                         in_act_store_dmem,
   input  logic                         in_act_write_res_to_reg,
   input  logic [P_DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
   input  logic [P_DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
   input  logic [P_DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
   input  logic [P_PMEM_WORD_WIDTH-1:0] in_instr,
   input  logic [P_PC_WIDTH-1:0]        in_pc,
   input  logic [P_IALU_WORD_WIDTH-1:0] in_res,
   input  logic [P_REG_IDX_WIDTH-1:0]   in_res_reg_idx,
   input  logic                         in_dmem_ack,
   input  logic [P_DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
   output logic                         out_dmem_req,
   output logic                         out_dmem_we,
   output logic [P_DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
   output logic [P_DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
   output logic                         out_stall,
   output logic                         out_act_write_res_to_reg,
   output logic [P_IALU_WORD_WIDTH-1:0] out_res,
   output logic [P_REG_IDX_WIDTH-1:0]   out_res_reg_idx,
   output logic                         out_res_valid,
   output logic [P_PMEM_WORD_WIDTH-1:0] out_instr,
   output logic [P_PC_WIDTH-1:0]        out_pc,
   output logic                         out_dmem_err
);

   // Stage register
   logic                         r_ld;
   logic                         r_st;
   logic                         r_wr_res;
   logic [P_DMEM_ADDR_WIDTH-1:0] r_rd_addr;
   logic [P_DMEM_ADDR_WIDTH-1:0] r_wr_addr;
   logic [P_DMEM_WORD_WIDTH-1:0] r_wr_word;
   logic [P_PMEM_WORD_WIDTH-1:0] r_instr;
   logic [P_PC_WIDTH-1:0]        r_pc;
   logic [P_IALU_WORD_WIDTH-1:0] r_res;
   logic [P_REG_IDX_WIDTH-1:0]   r_res_reg_idx;

   logic w_op;
   logic w_is_store;
   logic w_stall;
   logic w_complete;
   logic w_abort;

   assign w_op       = r_ld | r_st;
   // A simultaneous load+store is treated as a load; the store is dropped.
   assign w_is_store = r_st & ~r_ld;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ld          <= 1'b0;
         r_st          <= 1'b0;
         r_wr_res      <= 1'b0;
         r_rd_addr     <= '0;
         r_wr_addr     <= '0;
         r_wr_word     <= '0;
         r_instr       <= '0;
         r_pc          <= '0;
         r_res         <= '0;
         r_res_reg_idx <= '0;
      end else if (!w_stall) begin
         r_ld          <= in_act_load_dmem;
         r_st          <= in_act_store_dmem;
         r_wr_res      <= in_act_write_res_to_reg;
         r_rd_addr     <= in_dmem_rd_addr;
         r_wr_addr     <= in_dmem_wr_addr;
         r_wr_word     <= in_dmem_wr_word;
         r_instr       <= in_instr;
         r_pc          <= in_pc;
         r_res         <= in_res;
         r_res_reg_idx <= in_res_reg_idx;
      end
   end

   dmem_req_fsm #(
      .TIMEOUT (P_DMEM_TIMEOUT)
   ) u_dmem_req_fsm (
      .clock         (clock),
      .reset         (reset),
      .in_op_valid   (w_op),
      .in_op_illegal (r_ld & r_st),
      .in_ack        (in_dmem_ack),
      .out_req       (out_dmem_req),
      .out_stall     (w_stall),
      .out_complete  (w_complete),
      .out_abort     (w_abort),
      .out_err       (out_dmem_err)
   );

   assign out_stall = w_stall;

   always_comb begin
      out_dmem_we              = 1'b0;
      out_dmem_addr            = '0;
      out_dmem_wdata           = '0;
      out_act_write_res_to_reg = 1'b0;
      out_res                  = '0;
      out_res_reg_idx          = '0;
      out_res_valid            = 1'b0;
      out_instr                = '0;
      out_pc                   = '0;
      if (!reset) begin
         out_dmem_we     = w_is_store;
         out_dmem_addr   = r_ld ? r_rd_addr : (r_st ? r_wr_addr : '0);
         out_dmem_wdata  = w_is_store ? r_wr_word : '0;
         out_instr       = r_instr;
         out_pc          = r_pc;
         out_res_reg_idx = r_res_reg_idx;
         if (!w_op) begin
            // Pass-through: no added latency.
            out_res                  = r_res;
            out_res_valid            = 1'b1;
            out_act_write_res_to_reg = r_wr_res;
         end else if (w_abort) begin
            // Timed-out access completes with a zero, non-writing result.
            out_res = '0;
         end else if (r_ld) begin
            out_res                  = w_complete ? in_dmem_rdata : r_res;
            out_res_valid            = w_complete;
            out_act_write_res_to_reg = w_complete & r_wr_res;
         end else begin
            out_res = r_res;
         end
      end
   end

endmodule : mem_access

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed bench for mem_access with a 4-cycle timeout. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge where the stage register and FSM update.
// -----------------------------------------------------------------------------
module tb_mem_access;

   logic        clock;
   logic        reset;
   logic        in_act_load_dmem;
   logic        in_act_store_dmem;
   logic        in_act_write_res_to_reg;
   logic [11:0] in_dmem_rd_addr;
   logic [11:0] in_dmem_wr_addr;
   logic [15:0] in_dmem_wr_word;
   logic [15:0] in_instr;
   logic [11:0] in_pc;
   logic [15:0] in_res;
   logic [3:0]  in_res_reg_idx;
   logic        in_dmem_ack;
   logic [15:0] in_dmem_rdata;
   logic        out_dmem_req;
   logic        out_dmem_we;
   logic [11:0] out_dmem_addr;
   logic [15:0] out_dmem_wdata;
   logic        out_stall;
   logic        out_act_write_res_to_reg;
   logic [15:0] out_res;
   logic [3:0]  out_res_reg_idx;
   logic        out_res_valid;
   logic [15:0] out_instr;
   logic [11:0] out_pc;
   logic        out_dmem_err;

   int n_pass  = 0;
   int n_total = 0;

   mem_access #(
      .P_DMEM_TIMEOUT (4)
   ) dut (
      .clock                    (clock),
      .reset                    (reset),
      .in_act_load_dmem         (in_act_load_dmem),
      .in_act_store_dmem        (in_act_store_dmem),
      .in_act_write_res_to_reg  (in_act_write_res_to_reg),
      .in_dmem_rd_addr          (in_dmem_rd_addr),
      .in_dmem_wr_addr          (in_dmem_wr_addr),
      .in_dmem_wr_word          (in_dmem_wr_word),
      .in_instr                 (in_instr),
      .in_pc                    (in_pc),
      .in_res                   (in_res),
      .in_res_reg_idx           (in_res_reg_idx),
      .in_dmem_ack              (in_dmem_ack),
      .in_dmem_rdata            (in_dmem_rdata),
      .out_dmem_req             (out_dmem_req),
      .out_dmem_we              (out_dmem_we),
      .out_dmem_addr            (out_dmem_addr),
      .out_dmem_wdata           (out_dmem_wdata),
      .out_stall                (out_stall),
      .out_act_write_res_to_reg (out_act_write_res_to_reg),
      .out_res                  (out_res),
      .out_res_reg_idx          (out_res_reg_idx),
      .out_res_valid            (out_res_valid),
      .out_instr                (out_instr),
      .out_pc                   (out_pc),
      .out_dmem_err             (out_dmem_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_op(input logic ld, input logic st, input logic wr,
                         input logic [11:0] rd_a, input logic [11:0] wr_a,
                         input logic [15:0] wr_w, input logic [15:0] res,
                         input logic [3:0] idx);
      in_act_load_dmem        = ld;
      in_act_store_dmem       = st;
      in_act_write_res_to_reg = wr;
      in_dmem_rd_addr         = rd_a;
      in_dmem_wr_addr         = wr_a;
      in_dmem_wr_word         = wr_w;
      in_res                  = res;
      in_res_reg_idx          = idx;
   endtask

   initial begin
      // Reset with junk on every input: all outputs must read 0.
      reset         = 1'b1;
      in_instr      = 16'hFFFF;
      in_pc         = 12'hFFF;
      in_dmem_ack   = 1'b1;
      in_dmem_rdata = 16'hFFFF;
      set_op(1'b1, 1'b1, 1'b1, 12'hFFF, 12'hFFF, 16'hFFFF, 16'hFFFF, 4'hF);
      @(negedge clock); #1;
      check("rst_req",   out_dmem_req, 0);
      check("rst_we",    out_dmem_we, 0);
      check("rst_addr",  out_dmem_addr, 0);
      check("rst_wdata", out_dmem_wdata, 0);
      check("rst_stall", out_stall, 0);
      check("rst_wr",    out_act_write_res_to_reg, 0);
      check("rst_res",   out_res, 0);
      check("rst_idx",   out_res_reg_idx, 0);
      check("rst_valid", out_res_valid, 0);
      check("rst_instr", out_instr, 0);
      check("rst_pc",    out_pc, 0);
      check("rst_err",   out_dmem_err, 0);

      // Pass-through
      reset         = 1'b0;
      in_dmem_ack   = 1'b0;
      in_dmem_rdata = 16'h0000;
      in_instr      = 16'hA001;
      in_pc         = 12'h100;
      set_op(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 16'h0000, 16'h1234, 4'd5);
      @(negedge clock); #1;
      check("pt_res",   out_res, 16'h1234);
      check("pt_valid", out_res_valid, 1);
      check("pt_wr",    out_act_write_res_to_reg, 1);
      check("pt_req",   out_dmem_req, 0);
      check("pt_stall", out_stall, 0);
      check("pt_idx",   out_res_reg_idx, 5);
      check("pt_instr", out_instr, 16'hA001);
      check("pt_pc",    out_pc, 12'h100);

      // Zero-wait load (write address set to a distinct value on purpose)
      set_op(1'b1, 1'b0, 1'b1, 12'h010, 12'h0FF, 16'h0000, 16'h7777, 4'd3);
      @(negedge clock);
      in_dmem_ack   = 1'b1;
      in_dmem_rdata = 16'hBEEF;
      #1;
      check("ld0_req",   out_dmem_req, 1);
      check("ld0_we",    out_dmem_we, 0);
      check("ld0_addr",  out_dmem_addr, 12'h010);
      check("ld0_res",   out_res, 16'hBEEF);
      check("ld0_wr",    out_act_write_res_to_reg, 1);
      check("ld0_valid", out_res_valid, 1);
      check("ld0_stall", out_stall, 0);
      check("ld0_err",   out_dmem_err, 0);
      // Store presented now; it is sampled on the load's completion edge.
      set_op(1'b0, 1'b1, 1'b1, 12'h0EE, 12'h020, 16'h00A5, 16'h5555, 4'd7);

      // Store with ack after three stall cycles
      @(negedge clock);
      in_dmem_ack = 1'b0;
      #1;
      // Next op presented early; it must not be captured until the ack edge.
      set_op(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 16'h0000, 16'h4321, 4'd9);
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) begin
            @(negedge clock); #1;
         end
         check("st_req",   out_dmem_req, 1);
         check("st_we",    out_dmem_we, 1);
         check("st_addr",  out_dmem_addr, 12'h020);
         check("st_wdata", out_dmem_wdata, 16'h00A5);
         check("st_stall", out_stall, 1);
         check("st_wr",    out_act_write_res_to_reg, 0);
         check("st_idx",   out_res_reg_idx, 7);
      end
      @(negedge clock);
      in_dmem_ack = 1'b1;
      #1;
      check("st_ack_req",   out_dmem_req, 1);
      check("st_ack_addr",  out_dmem_addr, 12'h020);
      check("st_ack_stall", out_stall, 0);
      check("st_ack_wr",    out_act_write_res_to_reg, 0);
      check("st_ack_valid", out_res_valid, 0);
      check("st_ack_res",   out_res, 16'h5555);
      @(negedge clock);
      in_dmem_ack = 1'b0;
      #1;
      check("st_next_res",   out_res, 16'h4321);
      check("st_next_valid", out_res_valid, 1);
      check("st_next_idx",   out_res_reg_idx, 9);

      // Timeout: load that never gets an ack (timeout = 4)
      set_op(1'b1, 1'b0, 1'b1, 12'h0AB, 12'h000, 16'h0000, 16'h9999, 4'd2);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clock); #1;
         check("to_req",   out_dmem_req, 1);
         check("to_addr",  out_dmem_addr, 12'h0AB);
         check("to_err",   out_dmem_err, (i == 5));
         check("to_stall", out_stall, (i != 5));
         if (i == 5) begin
            check("to_wr",    out_act_write_res_to_reg, 0);
            check("to_res",   out_res, 0);
            check("to_valid", out_res_valid, 0);
         end
         if (i == 1) begin
            // Illegal load+store queued behind the timing-out load.
            set_op(1'b1, 1'b1, 1'b1, 12'h033, 12'h044, 16'hDEAD, 16'h0000, 4'd4);
         end
      end

      // Illegal load+store: read to rd_addr, err only in the first cycle
      @(negedge clock); #1;
      check("il_req",   out_dmem_req, 1);
      check("il_we",    out_dmem_we, 0);
      check("il_addr",  out_dmem_addr, 12'h033);
      check("il_wdata", out_dmem_wdata, 0);
      check("il_err",   out_dmem_err, 1);
      check("il_stall", out_stall, 1);
      @(negedge clock); #1;
      check("il_err2",  out_dmem_err, 0);
      check("il_req2",  out_dmem_req, 1);
      check("il_we2",   out_dmem_we, 0);
      @(negedge clock);
      in_dmem_ack   = 1'b1;
      in_dmem_rdata = 16'h1111;
      #1;
      check("il_res",   out_res, 16'h1111);
      check("il_wr",    out_act_write_res_to_reg, 1);
      check("il_we3",   out_dmem_we, 0);
      check("il_stall3", out_stall, 0);
      set_op(1'b1, 1'b0, 1'b1, 12'h050, 12'h000, 16'h0000, 16'h0000, 4'd6);

      // Reset during WAIT after two WAIT cycles
      @(negedge clock);
      in_dmem_ack = 1'b0;
      #1;
      check("rw_req1",   out_dmem_req, 1);
      check("rw_addr1",  out_dmem_addr, 12'h050);
      check("rw_stall1", out_stall, 1);
      @(negedge clock); #1;
      @(negedge clock); #1;
      check("rw_stall3", out_stall, 1);
      @(negedge clock);
      reset = 1'b1;
      set_op(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 16'h0000, 4'd0);
      in_instr = 16'h0000;
      in_pc    = 12'h000;
      #1;
      check("rw_req",   out_dmem_req, 0);
      check("rw_stall", out_stall, 0);
      check("rw_err",   out_dmem_err, 0);
      check("rw_addr",  out_dmem_addr, 0);
      check("rw_wr",    out_act_write_res_to_reg, 0);
      check("rw_valid", out_res_valid, 0);
      @(negedge clock);
      reset         = 1'b0;
      in_dmem_ack   = 1'b1;
      in_dmem_rdata = 16'hCAFE;
      #1;
      check("ia_req",   out_dmem_req, 0);
      check("ia_stall", out_stall, 0);
      check("ia_err",   out_dmem_err, 0);
      check("ia_res",   out_res, 0);
      check("ia_wr",    out_act_write_res_to_reg, 0);
      @(negedge clock); #1;
      check("ia_req2",  out_dmem_req, 0);
      check("ia_err2",  out_dmem_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_mem_access
